// File: rtl/hamming74_serial_decoder_pkg.sv
// Shared Hamming(7,4) definitions used by the encoder and the serial decoder.
// Codeword vectors are indexed so that bit i holds channel position i+1.
package hamming74_serial_decoder_pkg;

  localparam int unsigned HAM_N = 7;
  localparam int unsigned HAM_K = 4;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift
  } out_state_e;

  function automatic logic [2:0] ham74_syndrome(input logic [HAM_N-1:0] cw);
    logic [2:0] s;
    s[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
    s[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
    s[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
    return s;
  endfunction

  // Returns {d1, d2, d3, d4} so d1 (position 3) is the first bit sent out.
  function automatic logic [HAM_K-1:0] ham74_extract(input logic [HAM_N-1:0] cw);
    return {cw[2], cw[4], cw[5], cw[6]};
  endfunction

endpackage

// File: rtl/hamming74_serial_decoder_corrector.sv
// Combinational syndrome computation and single-bit correction of one codeword.
// With CORRECT_EN = 0 the syndrome is still produced but the data bits pass raw.
module hamming74_syndrome_corrector
  import hamming74_serial_decoder_pkg::*;
#(
  parameter bit CORRECT_EN = 1'b1
) (
  input  logic [HAM_N-1:0] codeword,
  output logic [HAM_K-1:0] data,
  output logic [2:0]       syndrome
);

  logic [HAM_N-1:0] flip_mask;
  logic [HAM_N-1:0] fixed_word;

  always_comb begin
    syndrome  = ham74_syndrome(codeword);
    flip_mask = '0;
    // The syndrome value is the 1-based position of the single flipped bit.
    if (CORRECT_EN && (syndrome != 3'd0)) begin
      flip_mask[syndrome - 3'd1] = 1'b1;
    end
    fixed_word = codeword ^ flip_mask;
    data       = ham74_extract(fixed_word);
  end

endmodule

// File: rtl/hamming74_serial_decoder.sv
// Serial Hamming(7,4) decoder: gathers 7 valid channel bits, corrects one error,
// and replays the 4 data bits on consecutive cycles with a per-word error pulse.
module hamming74_serial_decoder
  import hamming74_serial_decoder_pkg::*;
#(
  parameter bit          CORRECT_EN    = 1'b1,
  parameter int unsigned ERR_CNT_WIDTH = 16
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     DATA_IN,
  input  logic                     DATA_IN_VALID,
  output logic                     DATA_OUT,
  output logic                     DATA_OUT_VALID,
  output logic                     WORD_ERR,
  output logic [ERR_CNT_WIDTH-1:0] ERR_CNT
);

  logic [2:0]               bit_cnt_q;
  logic [HAM_N-1:0]         cw_q;
  logic                     word_done_q;
  logic [HAM_K-1:0]         hold_q;
  logic                     word_err_q;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q;
  out_state_e               state_q, state_d;
  logic [1:0]               idx_q, idx_d;

  logic [HAM_K-1:0]         corr_data;
  logic [2:0]               syndrome;
  logic                     last_bit;

  hamming74_syndrome_corrector #(
    .CORRECT_EN (CORRECT_EN)
  ) u_corrector (
    .codeword (cw_q),
    .data     (corr_data),
    .syndrome (syndrome)
  );

  assign last_bit = (bit_cnt_q == 3'(HAM_N - 1));

  // Bits shift in from the top, so after 7 shifts position 1 sits at cw_q[0].
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bit_cnt_q   <= 3'd0;
      cw_q        <= '0;
      word_done_q <= 1'b0;
    end else begin
      word_done_q <= DATA_IN_VALID && last_bit;
      if (DATA_IN_VALID) begin
        cw_q      <= {DATA_IN, cw_q[HAM_N-1:1]};
        bit_cnt_q <= last_bit ? 3'd0 : bit_cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hold_q     <= '0;
      word_err_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      word_err_q <= 1'b0;
      if (word_done_q) begin
        hold_q     <= corr_data;
        word_err_q <= (syndrome != 3'd0);
        if ((syndrome != 3'd0) && (err_cnt_q != {ERR_CNT_WIDTH{1'b1}})) begin
          err_cnt_q <= err_cnt_q + ERR_CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdle;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: ;
      StLoad: begin
        state_d = StShift;
        idx_d   = 2'd0;
      end
      StShift: begin
        if (idx_q < 2'd3) begin
          idx_d = idx_q + 2'd1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // A completed word always restarts the burst, even mid-shift.
    if (word_done_q) begin
      state_d = StLoad;
    end
  end

  always_comb begin
    DATA_OUT_VALID = 1'b0;
    DATA_OUT       = 1'b0;
    if (state_q == StShift) begin
      DATA_OUT_VALID = 1'b1;
      DATA_OUT       = hold_q[2'd3 - idx_q];
    end
    WORD_ERR = word_err_q;
    ERR_CNT  = err_cnt_q;
  end

endmodule

// File: tb/tb_hamming74_serial_decoder.sv
// Directed bench for the serial Hamming(7,4) decoder: table of codewords plus
// gapped, reset-abort, saturation, bypass and back-to-back random sequences.
module tb_hamming74_serial_decoder;

  logic        CLK;
  logic        RESET_N;
  logic        DATA_IN;
  logic        DATA_IN_VALID;

  logic        dout, dout_v, werr;
  logic [15:0] ecnt;
  logic        s_dout, s_dout_v, s_werr;
  logic [1:0]  s_ecnt;
  logic        b_dout, b_dout_v, b_werr;
  logic [15:0] b_ecnt;

  int checks   = 0;
  int failures = 0;

  hamming74_serial_decoder dut (
    .CLK (CLK), .RESET_N (RESET_N), .DATA_IN (DATA_IN), .DATA_IN_VALID (DATA_IN_VALID),
    .DATA_OUT (dout), .DATA_OUT_VALID (dout_v), .WORD_ERR (werr), .ERR_CNT (ecnt)
  );

  hamming74_serial_decoder #(.CORRECT_EN (1'b1), .ERR_CNT_WIDTH (2)) dut_sat (
    .CLK (CLK), .RESET_N (RESET_N), .DATA_IN (DATA_IN), .DATA_IN_VALID (DATA_IN_VALID),
    .DATA_OUT (s_dout), .DATA_OUT_VALID (s_dout_v), .WORD_ERR (s_werr), .ERR_CNT (s_ecnt)
  );

  hamming74_serial_decoder #(.CORRECT_EN (1'b0), .ERR_CNT_WIDTH (16)) dut_byp (
    .CLK (CLK), .RESET_N (RESET_N), .DATA_IN (DATA_IN), .DATA_IN_VALID (DATA_IN_VALID),
    .DATA_OUT (b_dout), .DATA_OUT_VALID (b_dout_v), .WORD_ERR (b_werr), .ERR_CNT (b_ecnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // cw written as positions 1..7 left to right (MSB = position 1); data = {d1,d2,d3,d4}.
  typedef struct {
    logic [6:0] cw;
    logic [3:0] data;
    logic [3:0] raw;
    logic       err;
  } vec_t;

  vec_t vecs[11];
  int   exp_cnt;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic p1, p2, p3;
    p1 = d[3] ^ d[2] ^ d[0];
    p2 = d[3] ^ d[1] ^ d[0];
    p3 = d[2] ^ d[1] ^ d[0];
    return {p1, p2, d[3], p3, d[2], d[1], d[0]};
  endfunction

  // Ends right after the edge that samples the 7th bit, with valid deasserted.
  task automatic send_word(input logic [6:0] cw, input int gap);
    for (int i = 0; i < 7; i++) begin
      DATA_IN       = cw[6-i];
      DATA_IN_VALID = 1'b1;
      tick();
      DATA_IN_VALID = 1'b0;
      DATA_IN       = 1'b0;
      if (i < 6) repeat (gap) tick();
    end
  endtask

  task automatic check_word(input logic [3:0] d, input logic [3:0] raw, input logic e,
                            input int cnt);
    tick();
    chk("word_err", 32'(werr), 32'(e));
    chk("byp_word_err", 32'(b_werr), 32'(e));
    chk("err_cnt", 32'(ecnt), 32'(cnt));
    chk("valid_t1", 32'(dout_v), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("valid_burst", 32'(dout_v), 32'd1);
      chk("data_out", 32'(dout), 32'(d[3-i]));
      chk("byp_data_out", 32'(b_dout), 32'(raw[3-i]));
      if (i == 0) chk("word_err_pulse", 32'(werr), 32'd0);
    end
    tick();
    chk("valid_after", 32'(dout_v), 32'd0);
    chk("data_idle", 32'(dout), 32'd0);
  endtask

  initial begin
    int         b2b_err;
    int         b2b_valid;
    int         b2b_pulses;
    logic [3:0] q[$];

    vecs[0]  = '{7'b0110011, 4'b1011, 4'b1011, 1'b0};
    vecs[1]  = '{7'b1110011, 4'b1011, 4'b1011, 1'b1};
    vecs[2]  = '{7'b0010011, 4'b1011, 4'b1011, 1'b1};
    vecs[3]  = '{7'b0100011, 4'b1011, 4'b0011, 1'b1};
    vecs[4]  = '{7'b0111011, 4'b1011, 4'b1011, 1'b1};
    vecs[5]  = '{7'b0110111, 4'b1011, 4'b1111, 1'b1};
    vecs[6]  = '{7'b0110001, 4'b1011, 4'b1001, 1'b1};
    vecs[7]  = '{7'b0110010, 4'b1011, 4'b1010, 1'b1};
    vecs[8]  = '{7'b0000000, 4'b0000, 4'b0000, 1'b0};
    vecs[9]  = '{7'b1111111, 4'b1111, 4'b1111, 1'b0};
    vecs[10] = '{7'b0100100, 4'b0101, 4'b0100, 1'b1};

    RESET_N       = 1'b0;
    DATA_IN       = 1'b0;
    DATA_IN_VALID = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 32'(dout_v), 32'd0);
    chk("rst_data", 32'(dout), 32'd0);
    chk("rst_word_err", 32'(werr), 32'd0);
    chk("rst_err_cnt", 32'(ecnt), 32'd0);
    RESET_N = 1'b1;
    tick();

    exp_cnt = 0;
    foreach (vecs[v]) begin
      send_word(vecs[v].cw, 0);
      if (vecs[v].err) exp_cnt++;
      check_word(vecs[v].data, vecs[v].raw, vecs[v].err, exp_cnt);
    end
    chk("sat_err_cnt", 32'(s_ecnt), 32'd3);
    chk("byp_err_cnt", 32'(b_ecnt), 32'(exp_cnt));

    // Gaps of 3 idle cycles between bits must not stretch the output burst.
    send_word(7'b0110011, 3);
    check_word(4'b1011, 4'b1011, 1'b0, exp_cnt);

    // Partial word then reset: only the following clean word may come out.
    DATA_IN_VALID = 1'b1;
    DATA_IN = 1'b1;
    repeat (4) tick();
    DATA_IN_VALID = 1'b0;
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
    chk("reset_cnt_clear", 32'(ecnt), 32'd0);
    chk("reset_sat_clear", 32'(s_ecnt), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("no_spurious_valid", 32'(dout_v), 32'd0);
    end
    exp_cnt = 0;
    send_word(7'b0110011, 0);
    check_word(4'b1011, 4'b1011, 1'b0, 0);

    // Back-to-back random words with random single errors, continuous valid.
    b2b_err    = 0;
    b2b_valid  = 0;
    b2b_pulses = 0;
    fork
      begin
        for (int w = 0; w < 100; w++) begin
          logic [3:0] d;
          logic [6:0] cw;
          int         pos;
          d   = 4'($urandom_range(0, 15));
          pos = $urandom_range(0, 7);
          cw  = encode(d);
          if (pos != 0) begin
            cw = cw ^ (7'b1000000 >> (pos - 1));
            b2b_err++;
          end
          q.push_back(d);
          for (int i = 0; i < 7; i++) begin
            DATA_IN       = cw[6-i];
            DATA_IN_VALID = 1'b1;
            tick();
          end
        end
        DATA_IN_VALID = 1'b0;
        DATA_IN       = 1'b0;
      end
      begin
        logic [3:0] cur;
        int         bitn;
        bitn = 0;
        cur  = 4'd0;
        for (int c = 0; c < 720; c++) begin
          tick();
          if (werr) b2b_pulses++;
          if (dout_v) begin
            b2b_valid++;
            if (bitn == 0) begin
              if (q.size() == 0) begin
                chk("b2b_unexpected_word", 32'd1, 32'd0);
              end else begin
                cur = q.pop_front();
              end
            end
            chk("b2b_data", 32'(dout), 32'(cur[3-bitn]));
            bitn = (bitn + 1) % 4;
          end
        end
      end
    join
    chk("b2b_valid_cycles", 32'(b2b_valid), 32'd400);
    chk("b2b_words_left", 32'(q.size()), 32'd0);
    chk("b2b_err_pulses", 32'(b2b_pulses), 32'(b2b_err));
    chk("b2b_err_cnt", 32'(ecnt), 32'(b2b_err));
    chk("b2b_sat_cnt", 32'(s_ecnt), 32'((b2b_err > 3) ? 3 : b2b_err));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
